// File: rtl/xarb_mux.sv
// xarb_mux: parametrised N-channel output arbiter between the per-channel
// input FIFOs and the destination-side FIFOs. Picks at most one eligible
// channel per cycle, using manual, fixed-priority or round-robin selection.
// It pops that channel's FIFO combinationally and registers the head word,
// its destination field and the channel index, with a valid flag.
module xarb_mux #(
  parameter int DATA_W = 10,
  parameter int DEST_W = 2,
  parameter int N_CH   = 4,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   fifo_data,
  input  logic [N_CH-1:0]          fifo_empty,
  output logic [N_CH-1:0]          fifo_pop,
  input  logic [(2**DEST_W)-1:0]   dest_full,
  input  logic [1:0]               mode,
  input  logic [CH_W-1:0]          sel,
  output logic [DATA_W-1:0]        data_inter,
  output logic [DEST_W-1:0]        destino,
  output logic                     valid_out,
  output logic [CH_W-1:0]          grant_ch
);

  // Selection modes; 2'b11 falls into round-robin through the case default.
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;

  logic [N_CH-1:0]   w_elig;
  logic              w_gnt;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [DATA_W-1:0] w_gnt_word;
  logic [CH_W-1:0]   w_ptr_next;
  int                w_scan;

  logic [DATA_W-1:0] r_data;
  logic [DEST_W-1:0] r_dest;
  logic              r_valid;
  logic [CH_W-1:0]   r_gch;
  logic [CH_W-1:0]   r_ptr;

  // A channel may be granted only if its FIFO holds a word and the
  // destination named by that head word is not almost full.
  for (genvar g = 0; g < N_CH; g++) begin : g_elig
    logic [DEST_W-1:0] w_dest;
    assign w_dest    = fifo_data[g*DATA_W + DATA_W - DEST_W +: DEST_W];
    assign w_elig[g] = ~fifo_empty[g] & ~dest_full[w_dest];
  end

  // Grant decision for the current mode; loops run from high to low index so
  // that the last match written (the lowest index / nearest to ptr) wins.
  always_comb begin
    w_gnt    = 1'b0;
    w_gnt_ch = '0;
    w_scan   = 0;
    case (mode)
      MODE_MANUAL: begin
        // sel values at or above N_CH never match a channel, so they give no grant.
        for (int c = N_CH - 1; c >= 0; c--) begin
          if ((CH_W'(c) == sel) && w_elig[c]) begin
            w_gnt    = 1'b1;
            w_gnt_ch = CH_W'(c);
          end else begin
            w_gnt    = w_gnt;
            w_gnt_ch = w_gnt_ch;
          end
        end
      end
      MODE_FIXED: begin
        for (int c = N_CH - 1; c >= 0; c--) begin
          if (w_elig[c]) begin
            w_gnt    = 1'b1;
            w_gnt_ch = CH_W'(c);
          end else begin
            w_gnt    = w_gnt;
            w_gnt_ch = w_gnt_ch;
          end
        end
      end
      default: begin
        // Round-robin: offset k from ptr, wrapped into 0..N_CH-1.
        for (int k = N_CH - 1; k >= 0; k--) begin
          w_scan = int'(r_ptr) + k;
          if (w_scan >= N_CH) begin
            w_scan = w_scan - N_CH;
          end else begin
            w_scan = w_scan;
          end
          if (w_elig[w_scan]) begin
            w_gnt    = 1'b1;
            w_gnt_ch = CH_W'(w_scan);
          end else begin
            w_gnt    = w_gnt;
            w_gnt_ch = w_gnt_ch;
          end
        end
      end
    endcase
  end

  // Head word of the granted channel.
  always_comb begin
    w_gnt_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (CH_W'(c) == w_gnt_ch) begin
        w_gnt_word = fifo_data[c*DATA_W +: DATA_W];
      end else begin
        w_gnt_word = w_gnt_word;
      end
    end
  end

  // Pointer successor, wrapping at N_CH which need not be a power of two.
  always_comb begin
    if ((int'(w_gnt_ch) + 1) >= N_CH) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_gnt_ch + CH_W'(1);
    end
  end

  // One-hot pop in the grant cycle; suppressed while reset is high so that
  // an arbitration in a reset cycle never consumes a word.
  always_comb begin
    if (reset) begin
      fifo_pop = '0;
    end else if (w_gnt) begin
      fifo_pop = {{(N_CH-1){1'b0}}, 1'b1} << w_gnt_ch;
    end else begin
      fifo_pop = '0;
    end
  end

  // Output registers and round-robin pointer; word fields hold on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_dest  <= '0;
      r_valid <= 1'b0;
      r_gch   <= '0;
      r_ptr   <= '0;
    end else begin
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_data <= w_gnt_word;
        r_dest <= w_gnt_word[DATA_W-1 -: DEST_W];
        r_gch  <= w_gnt_ch;
      end else begin
        r_data <= r_data;
        r_dest <= r_dest;
        r_gch  <= r_gch;
      end
      // ptr only advances on round-robin grants (mode 10 and 11).
      if (w_gnt && mode[1]) begin
        r_ptr <= w_ptr_next;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign data_inter = r_data;
  assign destino    = r_dest;
  assign valid_out  = r_valid;
  assign grant_ch   = r_gch;

endmodule

// File: tb/tb_xarb_mux.sv
// Self-checking bench for xarb_mux: the bench owns the input FIFOs as queues
// and predicts pops and registered outputs from the arbitration rules.
module tb_xarb_mux;
  localparam int DW = 10;
  localparam int NC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NC*DW-1:0] fifo_data;
  logic [NC-1:0]   fifo_empty, fifo_pop;
  logic [3:0]      dest_full;
  logic [1:0]      mode, sel;
  logic [DW-1:0]   data_inter;
  logic [1:0]      destino, grant_ch;
  logic            valid_out;

  // Three-channel instance for the non-power-of-two case.
  logic [3*DW-1:0] f3_data;
  logic [2:0]      f3_empty, f3_pop;
  logic [3:0]      f3_full;
  logic [1:0]      f3_mode, f3_sel;
  logic [DW-1:0]   f3_dout;
  logic [1:0]      f3_dest, f3_gch;
  logic            f3_valid;

  xarb_mux #(.DATA_W(10), .DEST_W(2), .N_CH(4), .CH_W(2)) dut (
    .clk(clk), .reset(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .dest_full(dest_full), .mode(mode), .sel(sel),
    .data_inter(data_inter), .destino(destino), .valid_out(valid_out),
    .grant_ch(grant_ch));

  xarb_mux #(.DATA_W(10), .DEST_W(2), .N_CH(3), .CH_W(2)) dut3 (
    .clk(clk), .reset(rst), .fifo_data(f3_data), .fifo_empty(f3_empty),
    .fifo_pop(f3_pop), .dest_full(f3_full), .mode(f3_mode), .sel(f3_sel),
    .data_inter(f3_dout), .destino(f3_dest), .valid_out(f3_valid),
    .grant_ch(f3_gch));

  logic [DW-1:0] q[NC][$];

  int            m_ptr;
  logic [DW-1:0] m_data;
  logic [1:0]    m_dest, m_gch;
  logic          m_valid;

  int errors = 0;
  int checks = 0;
  logic [3:0] obs_pop;
  logic [2:0] obs_pop3;
  logic       obs_valid_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int c);
    logic [DW-1:0] h;
    if (q[c].size() == 0) return 1'b0;
    h = q[c][0];
    return !dest_full[h[9:8]];
  endfunction

  // Reference selection taken straight from the mode rules.
  task automatic pick(output bit g, output int ch);
    int c;
    g = 1'b0;
    ch = 0;
    if (rst) return;
    if (mode == 2'b00) begin
      if (int'(sel) < NC && elig(int'(sel))) begin g = 1'b1; ch = int'(sel); end
    end else if (mode == 2'b01) begin
      for (int i = 0; i < NC; i++) if (!g && elig(i)) begin g = 1'b1; ch = i; end
    end else begin
      for (int k = 0; k < NC; k++) begin
        c = (m_ptr + k) % NC;
        if (!g && elig(c)) begin g = 1'b1; ch = c; end
      end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      if (q[c].size() > 0) begin
        fifo_data[c*DW +: DW] = q[c][0];
        fifo_empty[c] = 1'b0;
      end else begin
        fifo_data[c*DW +: DW] = 10'($urandom);
        fifo_empty[c] = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive, check the combinational pop, advance the model
  // across the edge and check every registered output.
  task automatic tick();
    bit g;
    int ch;
    logic [3:0] exp_pop;
    drive();
    #1;
    pick(g, ch);
    exp_pop = g ? (4'b0001 << ch) : 4'b0000;
    obs_pop = fifo_pop;
    obs_pop3 = f3_pop;
    obs_valid_pre = valid_out;
    chk("fifo_pop", fifo_pop, exp_pop);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ptr = 0; m_data = '0; m_dest = '0; m_gch = '0; m_valid = 1'b0;
    end else begin
      m_valid = g;
      if (g) begin
        m_data = q[ch].pop_front();
        m_dest = m_data[9:8];
        m_gch  = 2'(ch);
        if (mode[1]) m_ptr = (ch + 1) % NC;
      end
    end
    chk("valid_out", valid_out, m_valid);
    chk("data_inter", data_inter, m_data);
    chk("destino", destino, m_dest);
    chk("grant_ch", grant_ch, m_gch);
  endtask

  task automatic clear_q();
    for (int c = 0; c < NC; c++) q[c].delete();
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int rr_seq[5] = '{1, 2, 3, 0, 1};
  int n3_seq[4] = '{0, 1, 2, 0};

  initial begin
    rst = 1'b1; mode = 2'b10; sel = 2'b00; dest_full = 4'b0000;
    fifo_data = '0; fifo_empty = '1;
    f3_data = {10'h0C3, 10'h055, 10'h0AA}; f3_empty = 3'b000; f3_full = 4'b0000;
    f3_mode = 2'b10; f3_sel = 2'b00;
    m_ptr = 0; m_data = '0; m_dest = '0; m_gch = '0; m_valid = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every FIFO non-empty, then release into round-robin.
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 4; i++) q[c].push_back({2'b00, 8'($urandom)});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop", obs_pop, 4'b0000);
      chk("rst_valid", valid_out, 1'b0);
    end
    rst = 1'b0;
    tick();
    chk("rel_pop", obs_pop, 4'b0001);
    chk("rel_valid_pre", obs_valid_pre, 1'b0);
    chk("rr_first", grant_ch, 2'd0);
    chk("rr_valid", valid_out, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq", grant_ch, rr_seq[i]);
      chk("rr_valid", valid_out, 1'b1);
    end

    // Backpressure: ch1 targets destination 2 which is full while ptr=1.
    clear_q();
    reset_cycle();
    mode = 2'b10;
    q[0].push_back(10'h011);
    q[1].push_back(10'b10_0000_0001);
    q[2].push_back(10'h022);
    q[2].push_back(10'h023);
    q[3].push_back(10'h033);
    tick();
    chk("bp_first", obs_pop, 4'b0001);
    dest_full = 4'b0100;
    tick();
    chk("bp_skip", obs_pop, 4'b0100);
    dest_full = 4'b0000;
    tick();
    chk("bp_next", obs_pop, 4'b1000);
    tick();
    chk("bp_ch1", obs_pop, 4'b0010);
    chk("bp_ch1_data", data_inter, 10'b10_0000_0001);

    // Fixed priority: ch0 drains before ch3 is served.
    clear_q();
    reset_cycle();
    mode = 2'b01;
    for (int i = 0; i < 3; i++) q[0].push_back({2'b01, 8'($urandom)});
    q[3].push_back(10'h3FF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_ch0", obs_pop, 4'b0001);
    end
    tick();
    chk("fp_ch3", obs_pop, 4'b1000);
    tick();
    chk("fp_idle", obs_pop, 4'b0000);

    // Manual mode on an empty channel, then the same channel filled.
    clear_q();
    reset_cycle();
    mode = 2'b00;
    sel = 2'd2;
    tick();
    chk("man_empty_pop", obs_pop, 4'b0000);
    chk("man_empty_valid", valid_out, 1'b0);
    q[2].push_back(10'h2A5);
    tick();
    chk("man_pop", obs_pop, 4'b0100);
    chk("man_data", data_inter, 10'h2A5);
    chk("man_dest", destino, 2'b10);
    chk("man_gch", grant_ch, 2'd2);

    // Three channels, all eligible: 0,1,2,0; manual sel=3 never grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("n3_gch", f3_gch, n3_seq[i]);
      chk("n3_valid", f3_valid, 1'b1);
    end
    f3_mode = 2'b00;
    f3_sel = 2'd3;
    tick();
    chk("n3_sel3_pop", obs_pop3, 3'b000);
    chk("n3_sel3_valid", f3_valid, 1'b0);

    // Randomised traffic, modes, backpressure and occasional reset.
    clear_q();
    reset_cycle();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 2) == 0 && q[c].size() < 6) q[c].push_back(10'($urandom));
      mode = 2'($urandom);
      sel = 2'($urandom);
      dest_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rst = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xarb_mux.md
# xarb_mux

Parametrised N-channel output arbiter that sits between the per-channel input FIFOs and the destination-side FIFOs of the router datapath. Each cycle it picks at most one non-empty channel whose head word's destination can accept data, pops that FIFO, and registers the word and its destination field. It is the successor of the fixed 4:1 selector: the channel count and widths are parameters, there are three selection modes, it does destination backpressure, and the output is registered with a valid flag.

## Interface
- DATA_W, 10, word width; destination field is the top DEST_W bits of the word.
- DEST_W, 2, destination field width; number of destinations N_DEST = 2**DEST_W.
- N_CH, 4, number of input channels (2..16, need not be a power of two).
- CH_W, 2, channel index width, ceil(log2(N_CH)).
- clk  in  1  single clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high.
- fifo_data  in  N_CH*DATA_W  head words, show-ahead; channel c occupies bits [c*DATA_W +: DATA_W].
- fifo_empty  in  N_CH  empty flag per channel.
- fifo_pop  out  N_CH  combinational one-hot pop, asserted in the grant cycle.
- dest_full  in  N_DEST  almost-full flag per destination FIFO.
- mode  in  2  selection mode: 00 = manual, 01 = fixed priority, 10 = round-robin, 11 = treated as 10.
- sel  in  CH_W  channel select, used only in manual mode.
- data_inter  out  DATA_W  registered word.
- destino  out  DEST_W  registered destination, equal to data_inter[DATA_W-1 -: DEST_W].
- valid_out  out  1  registered; data_inter and destino are valid this cycle.
- grant_ch  out  CH_W  registered index of the channel behind the current valid_out.

## Operation
- A channel c is eligible when fifo_empty[c]=0 and dest_full[dest(c)]=0, where dest(c) is the top DEST_W bits of channel c's head word.
- Manual mode: grant sel if sel is eligible and sel < N_CH. Otherwise there is no grant.
- Fixed priority mode: grant the lowest-index eligible channel.
- Round-robin mode: grant the first eligible channel at or after ptr, searching upward and wrapping from N_CH-1 to 0. On a grant to channel c, ptr <= (c+1) mod N_CH. ptr holds when there is no grant and in the other modes.
- On a grant to channel c:
  - fifo_pop = one-hot(c) in the same cycle.
  - Next edge: data_inter <= head word of c, destino <= its destination field, grant_ch <= c, valid_out <= 1.
- With no grant: fifo_pop = 0, valid_out <= 0, and data_inter, destino and grant_ch hold their previous values.
- At most one pop per cycle. A channel is never popped while it is empty, and never popped while its destination is full.
- A mode change takes effect in the same cycle's selection. ptr is not reset by a mode change.

## Timing
- Reset values: data_inter=0, destino=0, valid_out=0, grant_ch=0, ptr=0.
- While reset is high, fifo_pop is forced to 0. An arbitration that would happen in a reset cycle is discarded.
- Latency: a pop in cycle T gives valid_out=1 with that word in cycle T+1.
- Throughput: one word per cycle while any channel is eligible.
- dest_full is sampled in the grant cycle only. A word already registered is not retracted if its destination becomes full afterwards. The downstream almost-full margin absorbs that one word.
- Simultaneous eligibility: the decision uses that cycle's ptr. All N_CH requesting continuously gives grants c, c+1, … wrapping with no repeats, so each channel is granted once per N_CH cycles.
- Reset raised mid-stream: no pop occurs in that cycle, outputs take their reset values on the edge, and ptr returns to 0.

## Test plan
- Reset: hold reset with all FIFOs non-empty -> fifo_pop=0 throughout. On the first cycle after release, in round-robin mode, pop channel 0. valid_out=0 until the edge that follows that pop.
- Round-robin fairness: N_CH=4, all channels non-empty, dest_full=0 -> grant_ch sequence 0,1,2,3,0,1 and valid_out held high.
- Backpressure: ch1 head 10'b10_xxxxxxxx, dest_full=4'b0100, mode round-robin, ptr=1 -> ch1 is skipped and ch2 is granted. After dest_full clears, ch1 is granted once its turn comes back.
- Fixed priority: ch0 and ch3 non-empty, mode 01 -> ch0 is popped every cycle until it is empty, and only then ch3.
- Manual mode: mode 00 with sel=2 and ch2 empty -> no pop and valid_out=0. Fill ch2 with 10'h2A5 -> the next cycle pops it, then data_inter=10'h2A5, destino=2'b10, grant_ch=2.
- Non-power-of-two: N_CH=3, CH_W=2, all channels eligible -> grants 0,1,2,0. Manual sel=3 -> no grant.
